axi_write_master: RTL and testbench
===================================

Name: axi_write_master

Overview:
Initiator end of the codebase's AXI4-Lite-style write path. It accepts a single-beat write command (address, data, byte strobes) on a simple valid/ready user port. It drives the AW and W channels concurrently, then collects the B response and reports completion. Only one transaction is outstanding at a time, and an optional watchdog flags a write response that never arrives.

Parameters:
ADDR_W, 32, address width on cmd_addr and AWADDR
DATA_W, 32, data width; WSTRB width is DATA_W/8
TIMEOUT, 256, max cycles spent in RESP before timeout_err sets; 0 disables the watchdog

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESET  in  1  reset; asynchronous, active-low (0 = reset)
cmd_valid  in  1  user command present
cmd_ready  out  1  block can accept a command
cmd_addr  in  ADDR_W  write address
cmd_data  in  DATA_W  write data
cmd_strb  in  DATA_W/8  byte strobes
done  out  1  one-cycle pulse: transaction completed
done_resp  out  2  BRESP captured for the completed transaction
busy  out  1  transaction in flight
timeout_err  out  1  sticky watchdog flag
AWADDR  out  ADDR_W  write address channel
AWVALID  out  1
AWREADY  in  1
WDATA  out  DATA_W  write data channel
WSTRB  out  DATA_W/8
WVALID  out  1
WREADY  in  1
BRESP  in  2  00 OKAY, 01 EXOKAY, 10 SLVERR, 11 DECERR
BVALID  in  1
BREADY  out  1

Behaviour:
- Reset (ARESET=0, async): state=IDLE. All outputs 0 except cmd_ready=1. Command registers cleared. Reset mid-transaction drops AWVALID/WVALID/BREADY immediately; no done pulse is generated.
- States: IDLE, SEND, RESP.
- IDLE:
  - cmd_ready=1, busy=0.
  - On cmd_valid at the edge: latch addr/data/strb, clear aw_done/w_done, clear timeout_err, go to SEND.
- SEND:
  - Entered 1 cycle after acceptance, with AWVALID=1 and WVALID=1 registered in the same cycle.
  - AWADDR/WDATA/WSTRB are driven from the latched registers and stay stable while valid.
  - AWVALID falls the cycle after an edge where AWVALID&&AWREADY; aw_done sets. WVALID/w_done behave the same way, independently.
  - Channels may complete in either order or on the same edge.
  - When both are done (counting a same-edge completion): go to RESP.
  - Valids never depend combinationally on READY, and never deassert before their handshake.
- RESP:
  - BREADY=1 registered.
  - On BVALID&&BREADY at the edge: done_resp<=BRESP, done<=1 for exactly one cycle, BREADY<=0, go to IDLE. cmd_ready is 1 in that same next cycle.
  - BVALID arriving before RESP is not accepted; BREADY stays 0 until RESP.
- Minimum latency, slave ready throughout: acceptance edge T, AW/W handshake at T+1, BREADY high from T+2, B handshake at T+2 if BVALID is already high, done at T+3.
- Outputs: busy = (state != IDLE); cmd_ready = (state == IDLE).
- Watchdog:
  - Counter cleared on entry to RESP, increments each RESP cycle without a B handshake.
  - When the count reaches TIMEOUT (TIMEOUT != 0), timeout_err sets and stays set.
  - The FSM keeps waiting for B, since the protocol permits no abort.
  - The counter saturates and does not wrap.
- done_resp holds its value until the next completion.

Decomposition:
- Shared package axi_pkg:
  - BRESP encoding constants RESP_OKAY/EXOKAY/SLVERR/DECERR.
  - State encoding for IDLE/SEND/RESP.
  - Default address/data widths.
- Optional sub-module axi_valid_hold: a single-channel valid register with a done flag, instantiated twice (AW and W). Everything else stays flat.

Test Plan:
- Slave always ready, BVALID returned 1 cycle after W: cmd addr=0x4, data=0xA1B2C3D4, strb=0xF -> AWADDR=0x4, WDATA=0xA1B2C3D4, WSTRB=0xF for one cycle each; done at T+3 with done_resp=00.
- AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops after 1 cycle; AWVALID held stable 4 cycles with AWADDR constant; BREADY rises only after the AW handshake.
- WREADY and AWREADY handshake on the same edge; BRESP=10 -> RESP entered next cycle; done_resp=10; cmd_ready=1 in the done cycle.
- TIMEOUT=8, BVALID withheld 20 cycles -> timeout_err=1 after 8 RESP cycles and stays 1; B arrives later -> done pulses; next command acceptance clears timeout_err.
- ARESET asserted asynchronously in SEND -> AWVALID=WVALID=0 with no clock edge; no done pulse; after release cmd_ready=1 and a new write completes normally.
- Back-to-back: cmd_valid held high with 3 commands -> each accepted only while in IDLE; exactly 3 done pulses, in order.

Source files
------------

// File: rtl/axi_pkg.sv
// axi_pkg: shared constants for the AXI-Lite write path (responses, FSM states, default widths)
package axi_pkg;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
endpackage

// File: rtl/axi_valid_hold.sv
// axi_valid_hold: one channel's VALID register plus a sticky handshake-done flag
module axi_valid_hold (
    input  logic ACLK,
    input  logic ARESET,
    input  logic start,
    input  logic ready,
    output logic valid,
    output logic done
);
    // Raise valid on start, drop it and remember completion after the handshake edge
    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            valid <= 1'b0;
            done  <= 1'b0;
        end else if (start) begin
            valid <= 1'b1;
            done  <= 1'b0;
        end else if (valid && ready) begin
            valid <= 1'b0;
            done  <= 1'b1;
        end
    end
endmodule

// File: rtl/axi_write_master.sv
// axi_write_master: single-outstanding AXI-Lite write initiator with B-response watchdog
module axi_write_master
    import axi_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 256
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_data,
    input  logic [DATA_W/8-1:0] cmd_strb,
    output logic                done,
    output logic [1:0]          done_resp,
    output logic                busy,
    output logic                timeout_err,
    output logic [ADDR_W-1:0]   AWADDR,
    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [DATA_W-1:0]   WDATA,
    output logic [DATA_W/8-1:0] WSTRB,
    output logic                WVALID,
    input  logic                WREADY,
    input  logic [1:0]          BRESP,
    input  logic                BVALID,
    output logic                BREADY
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] T_MAX = CW'(TIMEOUT);

    logic [1:0]          state;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W/8-1:0] strb_q;
    logic [CW-1:0]       wd_cnt;
    logic                accept, aw_done, w_done, send_fin, b_hs;

    assign accept    = (state == ST_IDLE) && cmd_valid;
    assign send_fin  = (state == ST_SEND) && (aw_done || (AWVALID && AWREADY)) && (w_done || (WVALID && WREADY));
    assign b_hs      = BVALID && BREADY;
    assign cmd_ready = state == ST_IDLE;
    assign busy      = state != ST_IDLE;
    assign AWADDR    = addr_q;
    assign WDATA     = data_q;
    assign WSTRB     = strb_q;

    axi_valid_hold u_aw (
        .ACLK  (ACLK),
        .ARESET(ARESET),
        .start (accept),
        .ready (AWREADY),
        .valid (AWVALID),
        .done  (aw_done)
    );

    axi_valid_hold u_w (
        .ACLK  (ACLK),
        .ARESET(ARESET),
        .start (accept),
        .ready (WREADY),
        .valid (WVALID),
        .done  (w_done)
    );

    // Command capture, state sequencing, B acceptance and the one-cycle completion pulse
    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
            BREADY    <= 1'b0;
            done      <= 1'b0;
            done_resp <= RESP_OKAY;
        end else begin
            done <= 1'b0;
            if (accept) begin
                state  <= ST_SEND;
                addr_q <= cmd_addr;
                data_q <= cmd_data;
                strb_q <= cmd_strb;
            end else if (send_fin) begin
                state  <= ST_RESP;
                BREADY <= 1'b1;
            end else if (state == ST_RESP && b_hs) begin
                state     <= ST_IDLE;
                BREADY    <= 1'b0;
                done      <= 1'b1;
                done_resp <= BRESP;
            end
        end
    end

    // Watchdog: count unanswered RESP cycles, saturate, and latch the error once TIMEOUT is reached
    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else if (accept) begin
            timeout_err <= 1'b0;
        end else if (send_fin) begin
            wd_cnt <= '0;
        end else if (state == ST_RESP && !b_hs && wd_cnt != T_MAX) begin
            wd_cnt <= wd_cnt + CW'(1);
            if (TIMEOUT != 0 && wd_cnt + CW'(1) == T_MAX) timeout_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_axi_write_master.sv
// tb_axi_write_master: vector table, reset sequence and randomized transactions against a cycle-count model
module tb_axi_write_master;
    import axi_pkg::*;
    localparam int TO = 8;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          aw;
        int          w;
        int          b;
        logic [1:0]  resp;
        bit          early;
        bit          hold;
        int          lat;
    } vec_t;

    logic        ACLK = 1'b0, ARESET = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_data = '0;
    logic [3:0]  cmd_strb = '0;
    logic        AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0;
    logic [1:0]  BRESP = '0;
    logic        cmd_ready, done, busy, timeout_err, AWVALID, WVALID, BREADY;
    logic [1:0]  done_resp;
    logic [31:0] AWADDR, WDATA;
    logic [3:0]  WSTRB;
    logic [1:0]  prev_resp = RESP_OKAY;
    int          tests = 0, fails = 0;
    vec_t        vq[$];
    vec_t        rv;

    always #5 ACLK = ~ACLK;

    axi_write_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_strb(cmd_strb),
        .done(done), .done_resp(done_resp), .busy(busy), .timeout_err(timeout_err),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // n counts edges after the acceptance edge; the slave raises each READY after its delay,
    // B returns b cycles into RESP (or is already waiting when early), done follows one edge later
    task automatic run_txn(input vec_t v);
        int m, c;
        m = (v.aw > v.w) ? v.aw : v.w;
        chk("entry_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_addr  = v.addr;
        cmd_data  = v.data;
        cmd_strb  = v.strb;
        for (int n = 0; n <= v.lat; n++) begin
            @(posedge ACLK);
            #1;
            c = n - m - 1;
            if (c < 0) c = 0;
            if (c > v.b) c = v.b;
            chk($sformatf("ctrl a=%0h n=%0d", v.addr, n),
                {AWVALID, WVALID, BREADY, done, busy, cmd_ready, timeout_err},
                {n <= v.aw, n <= v.w, n >= m + 1 && n < v.lat, n == v.lat, n < v.lat, n >= v.lat, c >= TO});
            if (n <= v.aw) chk($sformatf("awaddr n=%0d", n), AWADDR, v.addr);
            if (n <= v.w) begin
                chk($sformatf("wdata n=%0d", n), WDATA, v.data);
                chk($sformatf("wstrb n=%0d", n), WSTRB, v.strb);
            end
            chk($sformatf("done_resp a=%0h n=%0d", v.addr, n), done_resp, n >= v.lat ? v.resp : prev_resp);
            if (n == 0 && !v.hold) begin
                cmd_valid = 1'b0;
                cmd_addr  = $urandom;
                cmd_data  = $urandom;
                cmd_strb  = 4'($urandom);
            end
            AWREADY = n >= v.aw;
            WREADY  = n >= v.w;
            BVALID  = n < v.lat && (v.early || n >= m + 1 + v.b);
            BRESP   = BVALID ? v.resp : ~v.resp;
        end
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        BVALID  = 1'b0;
        prev_resp = v.resp;
    endtask

    initial begin
        vq.push_back('{32'h04, 32'hA1B2C3D4, 4'hF, 0, 0, 0,  RESP_OKAY,   1'b0, 1'b0, 2});
        vq.push_back('{32'h10, 32'h11223344, 4'h3, 3, 0, 0,  RESP_OKAY,   1'b0, 1'b0, 5});
        vq.push_back('{32'h20, 32'h55667788, 4'hC, 2, 2, 1,  RESP_SLVERR, 1'b0, 1'b0, 5});
        vq.push_back('{32'h24, 32'h9ABCDEF0, 4'h1, 0, 4, 2,  RESP_EXOKAY, 1'b0, 1'b0, 8});
        vq.push_back('{32'h28, 32'hCAFEF00D, 4'h8, 2, 1, 0,  RESP_DECERR, 1'b1, 1'b0, 4});
        vq.push_back('{32'h30, 32'h0BADBEEF, 4'hF, 0, 0, 7,  RESP_OKAY,   1'b0, 1'b0, 9});
        vq.push_back('{32'h34, 32'h12345678, 4'h6, 0, 0, 8,  RESP_SLVERR, 1'b0, 1'b0, 10});
        vq.push_back('{32'h38, 32'hDEADBEEF, 4'hF, 1, 0, 20, RESP_DECERR, 1'b0, 1'b0, 23});
        vq.push_back('{32'h3C, 32'h00000001, 4'hF, 1, 0, 0,  RESP_OKAY,   1'b0, 1'b0, 3});
        vq.push_back('{32'h40, 32'hAAAA0001, 4'hF, 0, 0, 0,  RESP_OKAY,   1'b0, 1'b1, 2});
        vq.push_back('{32'h44, 32'hAAAA0002, 4'h3, 1, 1, 1,  RESP_SLVERR, 1'b0, 1'b1, 4});
        vq.push_back('{32'h48, 32'hAAAA0003, 4'hC, 0, 2, 0,  RESP_EXOKAY, 1'b0, 1'b0, 4});

        repeat (2) @(posedge ACLK);
        #1;
        chk("reset_ctrl", {AWVALID, WVALID, BREADY, done, busy, cmd_ready, timeout_err, done_resp}, 9'b000001000);
        chk("reset_regs", {AWADDR, WDATA, WSTRB}, 0);
        ARESET = 1'b1;
        @(posedge ACLK);
        #1;

        foreach (vq[i]) run_txn(vq[i]);
        @(posedge ACLK);
        #1;
        chk("done_one_cycle", {done, busy, cmd_ready}, 3'b001);

        cmd_addr  = 32'h50;
        cmd_data  = 32'h5EED5EED;
        cmd_strb  = 4'hF;
        cmd_valid = 1'b1;
        @(posedge ACLK);
        #1;
        cmd_valid = 1'b0;
        chk("send_before_rst", {AWVALID, WVALID, busy}, 3'b111);
        #3 ARESET = 1'b0;
        #1;
        chk("async_rst", {AWVALID, WVALID, BREADY, done, busy, cmd_ready, timeout_err}, 7'b0000010);
        @(posedge ACLK);
        #1;
        chk("rst_held", {AWVALID, WVALID, BREADY, done, busy, cmd_ready}, 6'b000001);
        chk("rst_regs", {AWADDR, WDATA, WSTRB, done_resp}, 0);
        ARESET = 1'b1;
        prev_resp = RESP_OKAY;
        @(posedge ACLK);
        #1;
        chk("post_rst_idle", {done, busy, cmd_ready}, 3'b001);
        run_txn('{32'h54, 32'h0F0F0F0F, 4'h5, 1, 2, 1, RESP_EXOKAY, 1'b0, 1'b0, 5});

        for (int i = 0; i < 40; i++) begin
            rv.addr  = $urandom;
            rv.data  = $urandom;
            rv.strb  = 4'($urandom);
            rv.aw    = $urandom_range(0, 3);
            rv.w     = $urandom_range(0, 3);
            rv.early = $urandom_range(0, 3) == 0;
            rv.b     = rv.early ? 0 : ($urandom_range(0, 7) == 0 ? $urandom_range(8, 11) : $urandom_range(0, 3));
            rv.resp  = 2'($urandom);
            rv.hold  = (i != 39) && ($urandom_range(0, 1) == 1);
            rv.lat   = ((rv.aw > rv.w) ? rv.aw : rv.w) + 2 + rv.b;
            run_txn(rv);
        end
        @(posedge ACLK);
        #1;
        chk("final_idle", {done, busy, cmd_ready}, 3'b001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
